// File: rtl/four_phase_channel_arbiter.sv
// four_phase_channel_arbiter
//   Shares one four-phase return-to-zero channel (rreq_o/reack_i) between two
//   four-phase requesters. All handshake inputs are synchronised. Requesters are
//   granted round-robin. The full RTZ sequence is relayed for the granted one.
//   A sticky flag reports a resource that stalls for TIMEOUT cycles.
// Ports
//   clk, rst        clock, async active-high reset
//   req0_i/ack0_o   requester 0 handshake (req async, ack registered)
//   req1_i/ack1_o   requester 1 handshake
//   rreq_o/reack_i  shared resource handshake (rreq registered, reack async)
//   busy_o          low exactly when the FSM is idle
//   gnt_id_o        current or last granted requester
//   err_o           sticky timeout flag, err_clr_i clears it (a set wins)

// Single-bit flop-chain synchroniser, one instance per asynchronous input.
module four_phase_channel_arbiter_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] r_chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_chain <= '0;
    else     r_chain <= {r_chain[STAGES-2:0], d};
  end

  assign q = r_chain[STAGES-1];
endmodule

module four_phase_channel_arbiter #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_W   = 8,
  parameter int TIMEOUT     = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic req0_i,
  input  logic req1_i,
  output logic ack0_o,
  output logic ack1_o,
  output logic rreq_o,
  input  logic reack_i,
  output logic busy_o,
  output logic gnt_id_o,
  output logic err_o,
  input  logic err_clr_i
);
  typedef enum logic [1:0] {S_IDLE, S_RREQ, S_ACKH, S_RREL} state_t;

  localparam logic [TIMEOUT_W-1:0] LP_TMO = TIMEOUT_W'(TIMEOUT);

  // Bit order: 0 = req0, 1 = req1, 2 = reack.
  logic [2:0] w_async;
  logic [2:0] w_sync;

  assign w_async = {reack_i, req1_i, req0_i};

  four_phase_channel_arbiter_sync #(.STAGES(SYNC_STAGES)) u_sync [2:0] (
    .clk (clk),
    .rst (rst),
    .d   (w_async),
    .q   (w_sync)
  );

  logic w_req0_s, w_req1_s, w_reack_s;
  assign w_req0_s  = w_sync[0];
  assign w_req1_s  = w_sync[1];
  assign w_reack_s = w_sync[2];

  state_t               r_state;
  logic                 r_last_gnt;
  logic                 r_gnt;
  logic                 r_ack0, r_ack1, r_rreq, r_busy, r_err;
  logic [TIMEOUT_W-1:0] r_cnt;

  logic                 w_req_gnt, w_winner, w_adv, w_wait, w_cnt_max, w_err_set;
  logic [TIMEOUT_W-1:0] w_cnt_inc;

  assign w_req_gnt = r_gnt ? w_req1_s : w_req0_s;

  // On a tie the requester that did not win last time goes next.
  assign w_winner = (w_req0_s && w_req1_s) ? ~r_last_gnt : w_req1_s;

  always_comb begin
    w_adv = 1'b0;
    case (r_state)
      S_IDLE:  w_adv = w_req0_s | w_req1_s;
      S_RREQ:  w_adv = w_reack_s;
      S_ACKH:  w_adv = ~w_req_gnt;
      S_RREL:  w_adv = ~w_reack_s;
      default: w_adv = 1'b1;
    endcase
  end

  // Only the two phases that wait on the resource are timed.
  assign w_wait    = ((r_state == S_RREQ) || (r_state == S_RREL)) && !w_adv;
  assign w_cnt_max = (r_cnt == '1);
  assign w_cnt_inc = r_cnt + 1'b1;
  // Fires once per wait, on the edge the counter becomes TIMEOUT.
  assign w_err_set = w_wait && !w_cnt_max && (w_cnt_inc == LP_TMO);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_last_gnt <= 1'b1;
      r_gnt      <= 1'b0;
      r_ack0     <= 1'b0;
      r_ack1     <= 1'b0;
      r_rreq     <= 1'b0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
      r_cnt      <= '0;
    end else begin
      if (w_err_set)      r_err <= 1'b1;
      else if (err_clr_i) r_err <= 1'b0;

      if (w_adv)                     r_cnt <= '0;
      else if (w_wait && !w_cnt_max) r_cnt <= w_cnt_inc;

      case (r_state)
        S_IDLE: if (w_adv) begin
          r_state    <= S_RREQ;
          r_rreq     <= 1'b1;
          r_busy     <= 1'b1;
          r_gnt      <= w_winner;
          r_last_gnt <= w_winner;
        end
        S_RREQ: if (w_adv) begin
          r_state <= S_ACKH;
          r_ack0  <= ~r_gnt;
          r_ack1  <= r_gnt;
        end
        S_ACKH: if (w_adv) begin
          r_state <= S_RREL;
          r_rreq  <= 1'b0;
        end
        S_RREL: if (w_adv) begin
          r_state <= S_IDLE;
          r_ack0  <= 1'b0;
          r_ack1  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ack0_o   = r_ack0;
  assign ack1_o   = r_ack1;
  assign rreq_o   = r_rreq;
  assign busy_o   = r_busy;
  assign gnt_id_o = r_gnt;
  assign err_o    = r_err;
endmodule

// File: tb/tb_four_phase_channel_arbiter.sv
// Bench for four_phase_channel_arbiter: directed timing steps plus a randomized
// two-requester / one-resource environment checked against protocol and
// round-robin rules.
module tb_four_phase_channel_arbiter;
  localparam int TMO = 200;

  logic clk = 1'b0;
  logic rst, req0_i, req1_i, reack_i, err_clr_i;
  logic ack0_o, ack1_o, rreq_o, busy_o, gnt_id_o, err_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  four_phase_channel_arbiter #(.SYNC_STAGES(2), .TIMEOUT_W(8), .TIMEOUT(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0_i    (req0_i),
    .req1_i    (req1_i),
    .ack0_o    (ack0_o),
    .ack1_o    (ack1_o),
    .rreq_o    (rreq_o),
    .reack_i   (reack_i),
    .busy_o    (busy_o),
    .gnt_id_o  (gnt_id_o),
    .err_o     (err_o),
    .err_clr_i (err_clr_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  function automatic logic sel_sig(input int sel);
    case (sel)
      0:       return rreq_o;
      1:       return ack0_o;
      2:       return ack1_o;
      default: return busy_o;
    endcase
  endfunction

  task automatic wait_out(input string tag, input int sel, input logic val, input int budget);
    bit hit = 0;
    for (int n = 0; n < budget; n++) begin
      tick;
      if (sel_sig(sel) === val) begin hit = 1; break; end
    end
    chk(tag, hit, 1);
  endtask

  // ---------------- environment: requesters, resource, reference rules ----
  logic [1:0] rq;
  logic [1:0] p_ack;
  logic       p_rreq;
  int want[2], issued[2], done[2], pend_since[2];
  int gate_pct, rdly_max, rcnt, rdly, cyc, last_cyc, last_id;
  bit have_last;
  int got_q[$];

  function automatic int q_at(input int k);
    return (k < got_q.size()) ? got_q[k] : -1;
  endfunction

  task automatic env_reset;
    got_q.delete();
    for (int i = 0; i < 2; i++) begin
      want[i] = 0; issued[i] = 0; done[i] = 0; pend_since[i] = 0;
    end
    rq = 2'b00; have_last = 0; rcnt = 0; rdly = 0; cyc = 0;
    p_rreq = rreq_o; p_ack = {ack1_o, ack0_o};
  endtask

  task automatic env_tick;
    logic [1:0] a;
    int g;
    bit starve;
    tick;
    cyc++;
    a = {ack1_o, ack0_o};
    chk("ack_excl", a[0] & a[1], 0);
    if (a[0]) chk("ack0_gnt", gnt_id_o, 0);
    if (a[1]) chk("ack1_gnt", gnt_id_o, 1);
    chk("err_quiet", err_o, 0);
    if (rreq_o && !p_rreq) begin
      g = int'(gnt_id_o);
      chk("grant_busy", busy_o, 1);
      // Same requester granted twice while the other waited through the whole previous grant.
      starve = have_last && (last_id == g) && rq[1-g] && (pend_since[1-g] <= last_cyc);
      chk("fair", starve, 0);
      got_q.push_back(g);
      have_last = 1; last_id = g; last_cyc = cyc;
    end
    if (!rreq_o && p_rreq) begin
      chk("rreq_fall_ack", a[gnt_id_o], 1);
      chk("rreq_fall_req", rq[gnt_id_o], 0);
    end
    for (int i = 0; i < 2; i++) begin
      if (a[i] && !p_ack[i]) chk("ack_rise_reack", reack_i, 1);
      if (!a[i] && p_ack[i]) done[i]++;
    end
    for (int i = 0; i < 2; i++) begin
      if (rq[i] && a[i]) rq[i] = 1'b0;
      else if (!rq[i] && !a[i] && want[i] > 0 && $urandom_range(99, 0) < gate_pct) begin
        rq[i] = 1'b1; want[i]--; issued[i]++; pend_since[i] = cyc;
      end
    end
    if (rreq_o !== reack_i) begin
      if (rcnt >= rdly) begin
        reack_i = rreq_o; rcnt = 0; rdly = $urandom_range(rdly_max, 0);
      end else rcnt++;
    end else rcnt = 0;
    req0_i = rq[0]; req1_i = rq[1];
    p_rreq = rreq_o; p_ack = a;
  endtask

  task automatic env_drain(input string tag, input int budget);
    int n = 0;
    while (n < budget && !(want[0] == 0 && want[1] == 0 && done[0] == issued[0] &&
                          done[1] == issued[1] && !busy_o)) begin
      env_tick; n++;
    end
    chk({tag, "_drain"}, n < budget, 1);
    chk({tag, "_done0"}, done[0], issued[0]);
    chk({tag, "_done1"}, done[1], issued[1]);
  endtask

  task automatic timeout_run(input bit clr_same);
    tick; req0_i = 1'b1;
    wait_out("tmo_rreq", 0, 1'b1, 20);
    for (int n = 1; n <= TMO + 5; n++) begin
      tick;
      if (n == TMO - 1) begin
        chk("tmo_err_before", err_o, 0);
        if (clr_same) err_clr_i = 1'b1;
      end
      if (n == TMO) begin
        chk(clr_same ? "tmo_set_wins" : "tmo_err_set", err_o, 1);
        err_clr_i = 1'b0;
      end
    end
    chk("tmo_hold_rreq", rreq_o, 1);
    chk("tmo_hold_ack",  ack0_o, 0);
    chk("tmo_hold_busy", busy_o, 1);
    reack_i = 1'b1;
    wait_out("tmo_ack", 1, 1'b1, 10);
    req0_i = 1'b0;
    wait_out("tmo_rrel", 0, 1'b0, 10);
    reack_i = 1'b0;
    wait_out("tmo_idle", 3, 1'b0, 10);
    chk("tmo_sticky", err_o, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp3[7];
    rst = 1'b1; req0_i = 1'b0; req1_i = 1'b0; reack_i = 1'b0; err_clr_i = 1'b0;
    rq = 2'b00; gate_pct = 100; rdly_max = 1;
    repeat (2) tick;
    chk("rst_ack0", ack0_o, 0);  chk("rst_ack1", ack1_o, 0);
    chk("rst_rreq", rreq_o, 0);  chk("rst_busy", busy_o, 0);
    chk("rst_gnt",  gnt_id_o, 0); chk("rst_err", err_o, 0);
    rst = 1'b0;

    // Simultaneous pair after reset, then a second pair: 0 first both times.
    env_reset; gate_pct = 100; rdly_max = 1;
    want[0] = 1; want[1] = 1;
    env_drain("tie1", 200);
    chk("tie1_n", got_q.size(), 2); chk("tie1_a", q_at(0), 0); chk("tie1_b", q_at(1), 1);
    env_reset; want[0] = 1; want[1] = 1;
    env_drain("tie2", 200);
    chk("tie2_n", got_q.size(), 2); chk("tie2_a", q_at(0), 0); chk("tie2_b", q_at(1), 1);

    // Single requester with exact edge timing.
    tick; req0_i = 1'b1;
    tick; chk("t1_rreq_k",  rreq_o, 0);
    tick; chk("t1_rreq_k1", rreq_o, 0);
    tick; chk("t1_rreq_k2", rreq_o, 1); chk("t1_busy", busy_o, 1); chk("t1_gnt", gnt_id_o, 0);
    repeat (3) tick;
    chk("t1_wait_rreq", rreq_o, 1); chk("t1_wait_ack", ack0_o, 0);
    reack_i = 1'b1;
    tick; chk("t1_ack_m",  ack0_o, 0);
    tick; chk("t1_ack_m1", ack0_o, 0);
    tick; chk("t1_ack_m2", ack0_o, 1); chk("t1_ack1_a", ack1_o, 0);
    req0_i = 1'b0;
    tick; chk("t1_rrel_p",  rreq_o, 1);
    tick; chk("t1_rrel_p1", rreq_o, 1);
    tick; chk("t1_rrel_p2", rreq_o, 0); chk("t1_ack_hold", ack0_o, 1);
    reack_i = 1'b0;
    tick; chk("t1_ack_q",  ack0_o, 1);
    tick; chk("t1_ack_q1", ack0_o, 1); chk("t1_busy_q1", busy_o, 1);
    tick; chk("t1_ack_q2", ack0_o, 0); chk("t1_idle", busy_o, 0);
    chk("t1_ack1_b", ack1_o, 0); chk("t1_gnt_end", gnt_id_o, 0);

    // Requester 1 re-requesting continuously while requester 0 is pending.
    env_reset; gate_pct = 100; rdly_max = 2;
    want[1] = 4;
    repeat (3) env_tick;
    want[0] = 3;
    env_drain("alt", 1000);
    exp3 = '{1, 0, 1, 0, 1, 0, 1};
    chk("alt_n", got_q.size(), 7);
    for (int k = 0; k < 7; k++) chk($sformatf("alt_%0d", k), q_at(k), exp3[k]);

    // Randomized traffic.
    env_reset; gate_pct = 25; rdly_max = 4;
    want[0] = 25; want[1] = 25;
    env_drain("rand", 20000);
    chk("rand_issued", issued[0] + issued[1], 50);

    // Resource stall: timeout, then clear; then clear colliding with a set.
    timeout_run(1'b0);
    tick; err_clr_i = 1'b1;
    tick; err_clr_i = 1'b0;
    chk("tmo_clear", err_o, 0);
    timeout_run(1'b1);

    // Reset in ACKH.
    tick; req0_i = 1'b1;
    wait_out("r5_rreq", 0, 1'b1, 20);
    reack_i = 1'b1;
    wait_out("r5_ack", 1, 1'b1, 20);
    #2 rst = 1'b1;
    #1;
    chk("r5_ack0", ack0_o, 0); chk("r5_rreq", rreq_o, 0);
    chk("r5_busy", busy_o, 0); chk("r5_err",  err_o, 0);
    req0_i = 1'b0; reack_i = 1'b0;
    repeat (2) tick;
    rst = 1'b0;
    env_reset; gate_pct = 100; rdly_max = 1;
    want[0] = 1; want[1] = 1;
    env_drain("r5_tie", 200);
    chk("r5_tie_a", q_at(0), 0); chk("r5_tie_b", q_at(1), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
